// File: rtl/dmem_port.sv
// dmem_port: memory-stage data-port controller.
// Takes one word load or store per instruction from the EX/MEM register, runs it
// over a req/ack data bus with variable latency, and stalls the pipeline until the
// transfer finishes. Returns registered load data or a one-cycle error pulse.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   m_ren, m_wen         load / store request from EX (store wins if both high)
//   m_addr, m_dout       byte address and store data
//   stall                hold EX/MEM and all upstream stages
//   ld_data, ld_valid    registered load result and its one-cycle valid pulse
//   mem_err              one-cycle pulse: misaligned address or bus timeout
//   bus_req, bus_we      bus request (held until ack) and write enable
//   bus_addr, bus_wdata  word-aligned address and write data
//   bus_rdata, bus_ack   read data and single-cycle completion pulse
module dmem_port #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m_ren,
  input  logic        m_wen,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_dout,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        mem_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic req;
  logic aligned;

  assign req     = m_ren | m_wen;
  assign aligned = (m_addr[1:0] == 2'b00);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ld_data_d = ld_data_q;
    we_d      = we_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (aligned) begin
            addr_d  = m_addr[31:2];
            wdata_d = m_dout;
            we_d    = m_wen;
            cnt_d   = 8'd0;
            err_d   = 1'b0;
            state_d = StBusy;
          end else begin
            // No bus access at all; report the fault in DONE.
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 8'd1;
        // Ack takes priority over an expiring timeout in the same cycle.
        if (bus_ack) begin
          if (!we_q) begin
            ld_data_d = bus_rdata;
          end
          err_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          ld_data_d = 32'd0;
          err_d     = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        // The served request is still on the inputs; never reissue it here.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      ld_data_q <= 32'd0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ld_data_q <= ld_data_d;
      we_q      <= we_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Gated by resetn so a request held during reset cannot stall the pipeline.
  assign stall     = resetn & (((state_q == StIdle) & req) | (state_q == StBusy));
  assign bus_req   = (state_q == StBusy);
  assign bus_we    = we_q;
  assign bus_addr  = {addr_q, 2'b00};
  assign bus_wdata = wdata_q;
  assign ld_data   = ld_data_q;
  // A misaligned store leaves we_q stale, but err_q masks ld_valid then.
  assign ld_valid  = (state_q == StDone) & ~err_q & ~we_q;
  assign mem_err   = (state_q == StDone) & err_q;

endmodule

// File: tb/tb_dmem_port.sv
// Self-checking bench for dmem_port with TIMEOUT=4. Each access pushes its
// expected result to a scoreboard queue; the entry is popped and compared when
// the DUT drops stall at the end of the access.
module tb_dmem_port;

  localparam int Tmo = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m_ren, m_wen;
  logic [31:0] m_addr, m_dout;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_valid, mem_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack;

  dmem_port #(.TIMEOUT(Tmo)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .m_ren     (m_ren),
    .m_wen     (m_wen),
    .m_addr    (m_addr),
    .m_dout    (m_dout),
    .stall     (stall),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .mem_err   (mem_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        e;
    logic [31:0] d;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ld_model;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          done_cyc = 0;
  int          req_rise_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge: start of a new cycle.
  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic idle();
    tick();
    m_ren = 1'b0;
    m_wen = 1'b0;
    bus_ack = 1'b0;
    #1;
    check_eq("idle_stall", 32'(stall), 32'd0);
  endtask

  // One access; ack_at = cycle of the ack pulse, 0 for none.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ack_at,
                        input logic [31:0] rdata);
    exp_t e;
    int   done_at;
    bit   finished;
    if (addr[1:0] != 2'b00) begin
      e = '{v: 1'b0, e: 1'b1, d: ld_model};
      done_at = 1;
    end else if (ack_at >= 1 && ack_at <= Tmo) begin
      e = '{v: ~wr, e: 1'b0, d: (wr ? ld_model : rdata)};
      done_at = ack_at + 1;
    end else begin
      e = '{v: 1'b0, e: 1'b1, d: 32'd0};
      done_at = Tmo + 1;
    end
    ld_model = e.d;
    sb.push_back(e);

    tick();
    m_ren = rd;
    m_wen = wr;
    m_addr = addr;
    m_dout = wdata;
    bus_ack = 1'b0;
    bus_rdata = rdata;
    #1;
    check_eq("c0_stall", 32'(stall), 32'd1);
    check_eq("c0_bus_req", 32'(bus_req), 32'd0);

    finished = 1'b0;
    for (int c = 1; c <= 20 && !finished; c++) begin
      tick();
      bus_ack = (c == ack_at);
      #1;
      if (!stall) begin
        finished = 1'b1;
        done_cyc = cyc;
        check_eq("done_cycle", 32'(c), 32'(done_at));
        check_eq("done_bus_req", 32'(bus_req), 32'd0);
        e = sb.pop_front();
        check_eq("ld_valid", 32'(ld_valid), 32'(e.v));
        check_eq("mem_err", 32'(mem_err), 32'(e.e));
        check_eq("ld_data", ld_data, e.d);
      end else begin
        if (c == 1) req_rise_cyc = cyc;
        check_eq("busy_req", 32'(bus_req), 32'd1);
        check_eq("busy_addr", bus_addr, {addr[31:2], 2'b00});
        check_eq("busy_we", 32'(bus_we), 32'(wr));
        if (wr) check_eq("busy_wdata", bus_wdata, wdata);
        check_eq("busy_no_valid", 32'(ld_valid | mem_err), 32'd0);
      end
    end
    if (!finished) check_eq("done_bound", 32'(stall), 32'd0);
    bus_ack = 1'b0;
  endtask

  initial begin
    int d1;
    resetn = 1'b0;
    m_ren = 1'b0;
    m_wen = 1'b0;
    m_addr = 32'd0;
    m_dout = 32'd0;
    bus_rdata = 32'd0;
    bus_ack = 1'b0;
    ld_model = 32'd0;
    tick();
    tick();
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_bus_req", 32'(bus_req), 32'd0);
    check_eq("rst_bus_we", 32'(bus_we), 32'd0);
    check_eq("rst_ld_valid", 32'(ld_valid), 32'd0);
    check_eq("rst_mem_err", 32'(mem_err), 32'd0);
    check_eq("rst_ld_data", ld_data, 32'd0);
    check_eq("rst_bus_addr", bus_addr, 32'd0);
    check_eq("rst_bus_wdata", bus_wdata, 32'd0);
    resetn = 1'b1;

    access(1'b1, 1'b0, 32'h0000_0100, 32'd0, 1, 32'hCAFE_BABE);
    idle();
    access(1'b0, 1'b1, 32'h0000_2004, 32'h1234_5678, 5, 32'hDEAD_0000);
    idle();
    access(1'b1, 1'b0, 32'h0000_0103, 32'd0, 0, 32'd0);
    idle();
    access(1'b1, 1'b0, 32'h0000_0040, 32'd0, 0, 32'h5555_AAAA);
    idle();
    access(1'b1, 1'b0, 32'h0000_0044, 32'd0, Tmo, 32'hA5A5_0F0F);
    idle();
    access(1'b0, 1'b1, 32'h0000_0082, 32'h0BAD_F00D, 0, 32'd0);
    idle();
    access(1'b1, 1'b1, 32'h0000_0080, 32'hFEED_BEEF, 2, 32'h1111_2222);
    idle();

    // Stray ack with no request must do nothing.
    tick();
    bus_ack = 1'b1;
    #1;
    check_eq("stray_ack_stall", 32'(stall), 32'd0);
    tick();
    bus_ack = 1'b0;
    #1;
    check_eq("stray_ack_req", 32'(bus_req), 32'd0);
    check_eq("stray_ack_valid", 32'(ld_valid), 32'd0);

    // Back-to-back loads with no idle gap.
    access(1'b1, 1'b0, 32'h0000_0200, 32'd0, 1, 32'h0102_0304);
    d1 = done_cyc;
    access(1'b1, 1'b0, 32'h0000_0204, 32'd0, 3, 32'h0506_0708);
    check_eq("b2b_gap", 32'(req_rise_cyc - d1), 32'd2);
    idle();

    // Asynchronous reset in BUSY cycle 2 with the request still held.
    tick();
    m_ren = 1'b1;
    m_addr = 32'h0000_0300;
    tick();
    tick();
    #1;
    check_eq("pre_rst_req", 32'(bus_req), 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("async_rst_req", 32'(bus_req), 32'd0);
    check_eq("async_rst_stall", 32'(stall), 32'd0);
    tick();
    m_ren = 1'b0;
    resetn = 1'b1;
    ld_model = 32'd0;
    #1;
    check_eq("post_rst_stall", 32'(stall), 32'd0);
    check_eq("post_rst_req", 32'(bus_req), 32'd0);
    check_eq("post_rst_ld_data", ld_data, 32'd0);
    access(1'b1, 1'b0, 32'h0000_0304, 32'd0, 2, 32'h7777_8888);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
